key_region_detector: RTL and testbench

//  Downstream consumer of the camera frame buffer (160x120 RGB333 canvas, 9-bit words,
//  1-cycle registered read). On a start pulse it raster-scans a horizontal key strip,

---
 rtl/key_region_detector.sv | 156 +++++++++++++++
 tb/tb_key_region_detector.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_region_detector.sv
// rtl/key_region_detector.sv - key strip scanner: per-key marker pixel counts, hysteresis, note on/off masks
module key_region_detector #(
    parameter int NUM_KEYS       = 8,
    parameter int X_START        = 0,
    parameter int KEY_WIDTH      = 20,
    parameter int Y_START        = 80,
    parameter int Y_END          = 119,
    parameter int R_MIN          = 5,
    parameter int G_MAX          = 3,
    parameter int B_MAX          = 3,
    parameter int PRESS_THRESH   = 40,
    parameter int RELEASE_THRESH = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8:0]          q,
    output logic [31:0]         addr,
    output logic                busy,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_on,
    output logic [NUM_KEYS-1:0] key_off,
    output logic                key_valid,
    output logic [15:0]         debug_out
);
    localparam int KIW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int KCW = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
    localparam logic [7:0]     COL_FIRST = 8'(X_START);
    localparam logic [7:0]     COL_LAST  = 8'(X_START + NUM_KEYS * KEY_WIDTH - 1);
    localparam logic [6:0]     ROW_FIRST = 7'(Y_START);
    localparam logic [6:0]     ROW_LAST  = 7'(Y_END);
    localparam logic [KCW-1:0] KC_LAST   = KCW'(KEY_WIDTH - 1);
    localparam logic [2:0]     R_MIN3    = 3'(R_MIN);
    localparam logic [2:0]     G_MAX3    = 3'(G_MAX);
    localparam logic [2:0]     B_MAX3    = 3'(B_MAX);
    localparam logic [15:0]    PRESS16   = 16'(PRESS_THRESH);
    localparam logic [15:0]    REL16     = 16'(RELEASE_THRESH);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, PUBLISH} state_t;
    state_t state_q, state_d;

    logic [6:0]          row_q;
    logic [7:0]          col_q;
    logic [KCW-1:0]      kcol_q;
    logic [KIW-1:0]      key_q;
    logic [KIW-1:0]      pkey_q;
    logic                pval_q;
    logic [15:0]         cnt_q [NUM_KEYS];
    logic [NUM_KEYS-1:0] kstate_q;
    logic [15:0]         debug_q;
    logic [NUM_KEYS-1:0] new_state;
    logic                last_pix;
    logic                pix_match;
    logic                accept;
    logic                publish;

    assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign accept   = (state_q == IDLE) && start;
    assign publish  = (state_q == PUBLISH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (last_pix) state_d = DRAIN;
            DRAIN:   state_d = PUBLISH;
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Raster position; the key index rides along with a per-key column counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q  <= '0;
            col_q  <= '0;
            kcol_q <= '0;
            key_q  <= '0;
        end else if (accept) begin
            row_q  <= ROW_FIRST;
            col_q  <= COL_FIRST;
            kcol_q <= '0;
            key_q  <= '0;
        end else if (state_q == SCAN && !last_pix) begin
            if (col_q == COL_LAST) begin
                col_q  <= COL_FIRST;
                row_q  <= row_q + 7'd1;
                kcol_q <= '0;
                key_q  <= '0;
            end else begin
                col_q <= col_q + 8'd1;
                if (kcol_q == KC_LAST) begin
                    kcol_q <= '0;
                    key_q  <= key_q + KIW'(1);
                end else begin
                    kcol_q <= kcol_q + KCW'(1);
                end
            end
        end
    end

    // Key tag travels one cycle behind the address to meet the read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pval_q <= 1'b0;
            pkey_q <= '0;
        end else begin
            pval_q <= (state_q == SCAN);
            pkey_q <= key_q;
        end
    end

    assign pix_match = pval_q && (q[8:6] >= R_MIN3) && (q[5:3] <= G_MAX3) && (q[2:0] <= B_MAX3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
        end else if (accept) begin
            for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
        end else if (pix_match && cnt_q[pkey_q] != 16'hFFFF) begin
            cnt_q[pkey_q] <= cnt_q[pkey_q] + 16'd1;
        end
    end

    always_comb begin
        new_state = kstate_q;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (kstate_q[k]) new_state[k] = !(cnt_q[k] < REL16);
            else             new_state[k] = (cnt_q[k] >= PRESS16);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kstate_q <= '0;
            debug_q  <= '0;
        end else if (publish) begin
            kstate_q <= new_state;
            debug_q  <= cnt_q[0];
        end
    end

    // Published values are shown combinationally during PUBLISH so they line up with key_valid.
    assign addr      = {7'd0, row_q, 8'd0, col_q, 2'd0};
    assign busy      = (state_q != IDLE);
    assign key_valid = publish;
    assign key_state = publish ? new_state : kstate_q;
    assign key_on    = publish ? (new_state & ~kstate_q) : '0;
    assign key_off   = publish ? (~new_state & kstate_q) : '0;
    assign debug_out = publish ? cnt_q[0] : debug_q;
endmodule

// File: tb/tb_key_region_detector.sv
// tb/tb_key_region_detector.sv - scoreboard bench for key_region_detector with a frame-level reference model
module tb_key_region_detector;
    localparam int NK = 8, KW = 20, XS = 0, Y0 = 80, Y1 = 119;
    localparam int SCAN_LAT = (Y1 - Y0 + 1) * NK * KW + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  q;
    logic [31:0] addr;
    logic        busy;
    logic [7:0]  key_state, key_on, key_off;
    logic        key_valid;
    logic [15:0] debug_out;

    always #5 clk = ~clk;

    key_region_detector dut (
        .clk(clk), .rst(rst), .start(start), .q(q), .addr(addr), .busy(busy),
        .key_state(key_state), .key_on(key_on), .key_off(key_off),
        .key_valid(key_valid), .debug_out(debug_out)
    );

    logic [8:0] fb [0:127][0:255];
    always @(posedge clk) q <= fb[addr[24:18]][addr[9:2]];

    typedef struct packed {
        logic [7:0]  st;
        logic [7:0]  on;
        logic [7:0]  off;
        logic [15:0] dbg;
    } exp_t;
    exp_t expq[$];

    int tests = 0, fails = 0;
    int cyc = 0, start_cyc = 0, kv_count = 0, addr_bad = 0;
    logic [7:0] model_ks = 8'h00;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_match(input logic [8:0] p);
        return (p[8:6] >= 3'd5) && (p[5:3] <= 3'd3) && (p[2:0] <= 3'd3);
    endfunction

    function automatic logic [8:0] rand_pix(input bit want_match);
        logic [8:0] p;
        p = 9'($urandom);
        while (is_match(p) != want_match) p = 9'($urandom);
        return p;
    endfunction

    // Reference: count matching pixels inside each key's rectangle, then apply hysteresis.
    task automatic model_push();
        int cnt [NK];
        logic [7:0] nw;
        exp_t e;
        for (int k = 0; k < NK; k++) begin
            cnt[k] = 0;
            for (int r = Y0; r <= Y1; r++)
                for (int c = XS + k * KW; c < XS + (k + 1) * KW; c++)
                    if (is_match(fb[r][c]) && cnt[k] < 65535) cnt[k]++;
            nw[k] = model_ks[k] ? (cnt[k] >= 20) : (cnt[k] >= 40);
        end
        e.st  = nw;
        e.on  = nw & ~model_ks;
        e.off = ~nw & model_ks;
        e.dbg = 16'(cnt[0]);
        expq.push_back(e);
        model_ks = nw;
    endtask

    task automatic clear_frame();
        for (int r = 0; r < 128; r++)
            for (int c = 0; c < 256; c++) fb[r][c] = 9'd0;
    endtask

    // Exactly n marker pixels at random spots in key k, random non-marker elsewhere in the key.
    task automatic fill_key(input int k, input int n);
        int placed = 0;
        int total = (Y1 - Y0 + 1) * KW;
        for (int p = 0; p < total; p++) begin
            int r = Y0 + p / KW;
            int c = XS + k * KW + p % KW;
            if (int'($urandom_range(0, total - p - 1)) < n - placed) begin
                fb[r][c] = rand_pix(1'b1);
                placed++;
            end else begin
                fb[r][c] = rand_pix(1'b0);
            end
        end
    endtask

    task automatic run_scan(input bit dup_start);
        int n;
        model_push();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        n = kv_count;
        @(negedge clk);
        start = 1'b0;
        check("first_addr", addr, {7'd0, 7'd80, 8'd0, 8'd0, 2'd0});
        check("busy_after_start", 32'(busy), 32'd1);
        if (dup_start) begin
            repeat (100) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < SCAN_LAT + 200 && kv_count == n; i++) @(negedge clk);
        check("scan_done", 32'(kv_count), 32'(n + 1));
        @(negedge clk);
        check("busy_dropped", 32'(busy), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every key_valid and polices idle outputs and addresses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (key_valid) begin
                    kv_count++;
                    if (expq.size() == 0) begin
                        check("unexpected_key_valid", 32'd1, 32'd0);
                    end else begin
                        e = expq.pop_front();
                        check("key_state", 32'(key_state), 32'(e.st));
                        check("key_on", 32'(key_on), 32'(e.on));
                        check("key_off", 32'(key_off), 32'(e.off));
                        check("debug_out", 32'(debug_out), 32'(e.dbg));
                        check("latency", 32'(cyc - start_cyc), 32'(SCAN_LAT));
                        check("last_addr", addr, {7'd0, 7'd119, 8'd0, 8'd159, 2'd0});
                    end
                end else begin
                    check("on_off_quiet", {16'd0, key_on, key_off}, 32'd0);
                end
                if (busy && (addr[31:25] != 0 || addr[17:10] != 0 || addr[1:0] != 0 ||
                             addr[24:18] < 7'd80 || addr[24:18] > 7'd119 || addr[9:2] >= 8'd160))
                    addr_bad++;
            end
        end
    end

    initial begin
        int n;
        int picks [7] = '{0, 19, 20, 39, 40, 41, 800};
        clear_frame();
        repeat (3) @(negedge clk);
        check("rst_addr", addr, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_key_state", 32'(key_state), 32'd0);
        check("rst_key_on", 32'(key_on), 32'd0);
        check("rst_key_off", 32'(key_off), 32'd0);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_debug_out", 32'(debug_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_scan(1'b0);

        for (int r = Y0; r <= Y1; r++)
            for (int c = 0; c < 20; c++) fb[r][c] = 9'b111_000_000;
        run_scan(1'b0);

        clear_frame(); fill_key(3, 45); run_scan(1'b0);
        clear_frame(); fill_key(3, 30); run_scan(1'b0);
        clear_frame(); fill_key(3, 19); run_scan(1'b0);
        clear_frame(); fill_key(5, 39); run_scan(1'b0);
        clear_frame(); fill_key(5, 40); run_scan(1'b0);

        clear_frame();
        fb[80][0]   = 9'b101_100_000;
        fb[81][0]   = 9'b100_000_000;
        fb[82][5]   = 9'b101_011_011;
        fb[79][0]   = 9'b111_000_000;
        fb[80][160] = 9'b111_000_000;
        fb[119][160] = 9'b111_000_000;
        run_scan(1'b0);

        for (int s = 0; s < 2; s++) begin
            clear_frame();
            for (int k = 0; k < NK; k++) fill_key(k, picks[$urandom_range(0, 6)]);
            run_scan(s == 1);
        end

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3000) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midscan_rst_busy", 32'(busy), 32'd0);
        check("midscan_rst_key_state", 32'(key_state), 32'd0);
        check("midscan_rst_key_valid", 32'(key_valid), 32'd0);
        rst = 1'b0;
        model_ks = 8'h00;
        n = kv_count;
        repeat (3500) @(negedge clk);
        check("no_publish_after_rst", 32'(kv_count), 32'(n));

        clear_frame();
        for (int r = Y0; r <= Y1; r++)
            for (int c = 0; c < 20; c++) fb[r][c] = 9'b111_000_000;
        run_scan(1'b0);

        check("addr_range", 32'(addr_bad), 32'd0);
        check("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
